flap_input_ctrl: RTL

- Producer side of the game's `flap` input.
- Conditions the raw Basys3 flap pushbutton: 2-FF synchronizer, debounce state machine, rising-edge detect.
- Holds a one-deep flap request and delivers it to the game logic as a level held for exactly one game-tick period.
- Sits between the board pin and the game block, all in the 100 MHz domain, with the game tick supplied as a single-cycle enable.

---
 rtl/flap_input_ctrl_if.sv | 22 ++
 rtl/flap_input_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/flap_input_ctrl_if.sv
// Signal bundle between the flap pushbutton conditioner and the game logic.
// The master side drives the raw button, tick and pause inputs; the slave side is the conditioner.
interface flap_input_ctrl_if;
   logic       btn_raw;
   logic       tick;
   logic       paused;
   logic       flap;
   logic       btn_level;
   logic       press_pulse;
   logic       merged;
   logic [7:0] press_count;

   modport master (
      output btn_raw, tick, paused,
      input  flap, btn_level, press_pulse, merged, press_count
   );

   modport slave (
      input  btn_raw, tick, paused,
      output flap, btn_level, press_pulse, merged, press_count
   );
endinterface

// File: rtl/flap_input_ctrl.sv
// Flap pushbutton conditioner: synchronizer, debounce FSM and rising-edge detect,
// feeding a one-deep request latch that presents flap as a level for one game tick.
module flap_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic               clk,
   input  logic               clr,
   flap_input_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic             r_pend;
   logic             r_flap;
   logic             r_merged;
   logic [7:0]       r_count;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_level_nxt;

   // btn_raw is asynchronous; only r_sync1 ever samples it
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= bus.btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_cnt_inc = r_cnt + C_ONE;

   // The qualifying edge counts itself, so the level flips when the incremented count hits the last value
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_LOW: begin
            if (r_sync2) begin
               w_state_nxt = ST_WAIT_HIGH;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT_HIGH: begin
            if (!r_sync2) begin
               w_state_nxt = ST_LOW;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc == C_LAST) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         ST_HIGH: begin
            if (!r_sync2) begin
               w_state_nxt = ST_WAIT_LOW;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT_LOW: begin
            if (r_sync2) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc == C_LAST) begin
               w_state_nxt = ST_LOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_WAIT_LOW);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
      end
   end

   // Pause outranks the tick; a press landing on a tick goes straight out and never merges
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
         r_pend    <= 1'b0;
         r_flap    <= 1'b0;
         r_merged  <= 1'b0;
         r_count   <= 8'd0;
      end else begin
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d & ~bus.paused;
         if (r_press) begin
            r_count <= r_count + 8'd1;
         end
         if (bus.paused) begin
            r_pend   <= 1'b0;
            r_flap   <= 1'b0;
            r_merged <= 1'b0;
         end else if (bus.tick) begin
            r_flap   <= r_pend | r_press;
            r_pend   <= 1'b0;
            r_merged <= 1'b0;
         end else begin
            r_pend   <= r_pend | r_press;
            r_merged <= r_press & r_pend;
         end
      end
   end

   assign bus.flap        = r_flap;
   assign bus.btn_level   = r_level;
   assign bus.press_pulse = r_press;
   assign bus.merged      = r_merged;
   assign bus.press_count = r_count;

endmodule
